uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one uart_tx instance between p_NUM_REQ independent requesters.
- Each requester presents a word and a request level. The arbiter picks one requester round-robin and latches its word.
- It then drives the transmitter's send/data inputs and holds ownership until the transmitter reports done.
- Sits between protocol/command logic and uart_tx; uart_rx is unaffected.

Parameters:
- p_NUM_REQ, 4, number of requesters (2..8).
- p_WORD_LEN, 8, data word width; must match the uart_tx instance.
- p_TIMEOUT, 2048, watchdog limit in i_clk cycles. Used only with the optional feature.

Ports:
- i_clk  input  1  system clock; all logic on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_req  input  p_NUM_REQ  per-requester request level; held until granted.
- i_data  input  p_NUM_REQ*p_WORD_LEN  requester k's word in bits [k*p_WORD_LEN +: p_WORD_LEN].
- o_gnt  output  p_NUM_REQ  one-hot, one-cycle pulse: word from that requester accepted.
- o_owner  output  $clog2(p_NUM_REQ)  index of current/last owner.
- o_busy  output  1  high from grant until transmitter done.
- o_tx_send  output  1  to uart_tx i_send.
- o_tx_data  output  p_WORD_LEN  to uart_tx i_data; stable for the whole frame.
- i_tx_active  input  1  from uart_tx o_active.
- i_tx_done  input  1  from uart_tx o_done.
- o_timeout  output  1  one-cycle pulse on watchdog abort (feature only; tied 0 otherwise).

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - State goes to IDLE.
  - All outputs go to 0: o_gnt, o_owner, o_busy, o_tx_send, o_tx_data, o_timeout.
  - Round-robin pointer goes to 0, so requester 0 has top priority next.
  - Reset mid-frame aborts ownership immediately. The transmitter is not reset by this block.
- States: IDLE, LOAD, SEND, WAIT_DONE.
- IDLE:
  - Waits until |i_req and i_tx_active==0.
  - Winner = first set i_req bit searching upward (wrapping) from pointer.
  - Latches the winner's word into o_tx_data and its index into o_owner.
  - Pulses o_gnt[winner] for exactly one cycle, sets o_busy, goes to LOAD.
  - Requester must drop i_req the cycle after seeing its o_gnt bit, or it re-enters arbitration.
- LOAD: one cycle so o_tx_data is registered before send. Asserts o_tx_send, goes to SEND.
- SEND:
  - Holds o_tx_send=1 until i_tx_active==1, then clears o_tx_send and goes to WAIT_DONE.
  - If i_tx_done is also 1 that cycle, goes straight to IDLE.
- WAIT_DONE:
  - On i_tx_done==1: clears o_busy, sets pointer = o_owner+1 (wrapping at p_NUM_REQ), goes to IDLE.
- Latency: i_req to o_gnt is 1 cycle; o_gnt to o_tx_send is 1 cycle.
- Back-to-back frames: the next grant is earliest 1 cycle after i_tx_done and requires i_tx_active==0.
- Simultaneous requests: exactly one grant per frame; fairness is round-robin.
- i_req changing during a frame does not affect the current owner or o_tx_data.
- i_tx_done in IDLE or LOAD is ignored.
- o_owner holds its last value while idle.

Optional Feature:
- Macro: UART_TX_ARBITER_TIMEOUT_EN.
- With the macro:
  - A counter clears on entering SEND and counts in SEND and WAIT_DONE.
  - When it reaches p_TIMEOUT-1 without i_tx_done: pulses o_timeout for one cycle, clears o_tx_send and o_busy, advances pointer as on done, goes to IDLE.
- Without the macro: no counter; o_timeout is constant 0; the arbiter waits indefinitely.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding localparams (IDLE=0, LOAD=1, SEND=2, WAIT_DONE=3);
  - default word length 8;
  - default clock divider 52.
- One sub-module, uart_rr_pick: combinational round-robin picker.
  - Inputs: request vector, pointer.
  - Outputs: one-hot winner, winner index, valid.
  - Reusable for a future rx-side distributor.

Test Plan:
- Single request: i_req=4'b0100, data[2]=8'h48 → o_gnt=4'b0100 one cycle; o_tx_send next cycle; uart_rx later returns 8'h48; o_busy falls 1 cycle after i_tx_done.
- All four requesting continuously, words 8'h41..8'h44 → grant order 0,1,2,3,0 after reset; received bytes 41,42,43,44,41.
- Pointer wrap: after owner 3, i_req=4'b1001 → grant requester 0, not 3.
- Request change mid-frame: during WAIT_DONE change data[owner] from 8'h55 to 8'hAA → received byte 8'h55; o_tx_data unchanged.
- Reset in WAIT_DONE: assert i_rst one cycle → all outputs 0 next cycle; next grant waits for i_tx_active==0 and goes to lowest-index requester.
- With UART_TX_ARBITER_TIMEOUT_EN, p_TIMEOUT=16, i_tx_done tied 0 → o_timeout pulses 16 cycles after entering SEND; state returns to IDLE; next requester granted.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and the tx arbiter state encoding
package uart_pkg;

   // Arbiter state encoding
   localparam logic [1:0] c_ST_IDLE      = 2'd0;
   localparam logic [1:0] c_ST_LOAD      = 2'd1;
   localparam logic [1:0] c_ST_SEND      = 2'd2;
   localparam logic [1:0] c_ST_WAIT_DONE = 2'd3;

   // Defaults shared by the uart_tx / uart_rx family
   localparam int c_WORD_LEN = 8;
   localparam int c_CLK_DIV  = 52;

   typedef enum logic [1:0] {
      IDLE      = c_ST_IDLE,
      LOAD      = c_ST_LOAD,
      SEND      = c_ST_SEND,
      WAIT_DONE = c_ST_WAIT_DONE
   } arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// rtl/uart_rr_pick.sv - combinational round-robin picker, first set request at or above the pointer
module uart_rr_pick #(
   parameter int p_NUM_REQ = 4,
   localparam int c_IW = $clog2(p_NUM_REQ)
) (
   input  logic [p_NUM_REQ-1:0] req,
   input  logic [c_IW-1:0]      ptr,
   output logic [p_NUM_REQ-1:0] onehot,
   output logic [c_IW-1:0]      idx,
   output logic                 valid
);

   // Walk offsets from farthest to nearest so the nearest set request overwrites the rest
   always_comb begin
      int k;
      k      = 0;
      onehot = '0;
      idx    = '0;
      valid  = 1'b0;
      for (int off = p_NUM_REQ - 1; off >= 0; off--) begin
         k = (int'(ptr) + off) % p_NUM_REQ;
         if (req[k]) begin
            valid     = 1'b1;
            idx       = c_IW'(k);
            onehot    = '0;
            onehot[k] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one uart_tx; optional watchdog under UART_TX_ARBITER_TIMEOUT_EN
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int p_NUM_REQ  = 4,
   parameter int p_WORD_LEN = c_WORD_LEN,
   parameter int p_TIMEOUT  = 2048
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic [p_NUM_REQ-1:0]            i_req,
   input  logic [p_NUM_REQ*p_WORD_LEN-1:0] i_data,
   output logic [p_NUM_REQ-1:0]            o_gnt,
   output logic [$clog2(p_NUM_REQ)-1:0]    o_owner,
   output logic                            o_busy,
   output logic                            o_tx_send,
   output logic [p_WORD_LEN-1:0]           o_tx_data,
   input  logic                            i_tx_active,
   input  logic                            i_tx_done,
   output logic                            o_timeout
);

   localparam int c_IW = $clog2(p_NUM_REQ);

   if (p_NUM_REQ < 2 || p_NUM_REQ > 8 || p_TIMEOUT < 2) begin : g_param_check
      $error("uart_tx_arbiter: parameter out of range");
   end

   arb_state_t            state, state_n;
   logic [c_IW-1:0]       ptr, ptr_n, owner_n, ptr_after;
   logic [p_NUM_REQ-1:0]  gnt_n;
   logic                  busy_n, send_n;
   logic [p_WORD_LEN-1:0] data_n;
   logic [p_NUM_REQ-1:0]  win_onehot;
   logic [c_IW-1:0]       win_idx;
   logic                  win_valid;

   uart_rr_pick #(.p_NUM_REQ(p_NUM_REQ)) u_pick (
      .req    (i_req),
      .ptr    (ptr),
      .onehot (win_onehot),
      .idx    (win_idx),
      .valid  (win_valid)
   );

   // Next priority starts just above the requester that owned the last frame
   assign ptr_after = (o_owner == c_IW'(p_NUM_REQ - 1)) ? '0 : o_owner + c_IW'(1);

`ifdef UART_TX_ARBITER_TIMEOUT_EN
   localparam int c_CW = $clog2(p_TIMEOUT);
   logic [c_CW-1:0] wd_cnt, wd_cnt_n;
   logic            timeout_n;
   logic            wd_expire;
   assign wd_expire = (wd_cnt == c_CW'(p_TIMEOUT - 1));
`endif

   // Next-state and next-output decode for the arbiter FSM
   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      owner_n = o_owner;
      gnt_n   = '0;
      busy_n  = o_busy;
      send_n  = o_tx_send;
      data_n  = o_tx_data;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
      wd_cnt_n  = wd_cnt;
      timeout_n = 1'b0;
`endif
      unique case (state)
         IDLE: begin
            if (win_valid && !i_tx_active) begin
               state_n = LOAD;
               gnt_n   = win_onehot;
               owner_n = win_idx;
               data_n  = i_data[int'(win_idx)*p_WORD_LEN +: p_WORD_LEN];
               busy_n  = 1'b1;
            end
         end
         LOAD: begin
            send_n  = 1'b1;
            state_n = SEND;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
            wd_cnt_n = '0;
`endif
         end
         SEND: begin
            if (i_tx_active) begin
               send_n = 1'b0;
               if (i_tx_done) begin
                  state_n = IDLE;
                  busy_n  = 1'b0;
                  ptr_n   = ptr_after;
               end else begin
                  state_n = WAIT_DONE;
               end
            end
         end
         WAIT_DONE: begin
            if (i_tx_done) begin
               state_n = IDLE;
               busy_n  = 1'b0;
               ptr_n   = ptr_after;
            end
         end
      endcase
`ifdef UART_TX_ARBITER_TIMEOUT_EN
      // Watchdog only runs while a frame is outstanding and not finishing this cycle
      if ((state == SEND || state == WAIT_DONE) && state_n != IDLE) begin
         if (wd_expire) begin
            timeout_n = 1'b1;
            send_n    = 1'b0;
            busy_n    = 1'b0;
            ptr_n     = ptr_after;
            state_n   = IDLE;
         end else begin
            wd_cnt_n = wd_cnt + c_CW'(1);
         end
      end
`endif
   end

   // State and registered outputs; reset abandons any frame in flight
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= IDLE;
         ptr       <= '0;
         o_owner   <= '0;
         o_gnt     <= '0;
         o_busy    <= 1'b0;
         o_tx_send <= 1'b0;
         o_tx_data <= '0;
      end else begin
         state     <= state_n;
         ptr       <= ptr_n;
         o_owner   <= owner_n;
         o_gnt     <= gnt_n;
         o_busy    <= busy_n;
         o_tx_send <= send_n;
         o_tx_data <= data_n;
      end
   end

`ifdef UART_TX_ARBITER_TIMEOUT_EN
   // Watchdog counter and its abort pulse
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wd_cnt    <= '0;
         o_timeout <= 1'b0;
      end else begin
         wd_cnt    <= wd_cnt_n;
         o_timeout <= timeout_n;
      end
   end
`else
   assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - table-driven and scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

   logic        clk;
   logic        i_rst;
   logic [3:0]  i_req;
   logic [31:0] i_data;
   logic [3:0]  o_gnt;
   logic [1:0]  o_owner;
   logic        o_busy;
   logic        o_tx_send;
   logic [7:0]  o_tx_data;
   logic        i_tx_active;
   logic        i_tx_done;
   logic        o_timeout;

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] sb[$];

   typedef struct {
      logic [3:0]  req;
      logic [31:0] data;
      logic [3:0]  gnt;
      logic [1:0]  own;
      logic [7:0]  word;
      int          act_dly;
      logic        mid_en;
      logic        same_cycle;
   } vec_t;

   vec_t vecs[11];

   uart_tx_arbiter #(.p_NUM_REQ(4), .p_WORD_LEN(8), .p_TIMEOUT(16)) dut (
      .i_clk       (clk),
      .i_rst       (i_rst),
      .i_req       (i_req),
      .i_data      (i_data),
      .o_gnt       (o_gnt),
      .o_owner     (o_owner),
      .o_busy      (o_busy),
      .o_tx_send   (o_tx_send),
      .o_tx_data   (o_tx_data),
      .i_tx_active (i_tx_active),
      .i_tx_done   (i_tx_done),
      .o_timeout   (o_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_sb(input string name);
      logic [7:0] e;
      if (sb.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: scoreboard empty, got %0h", name, o_tx_data);
      end else begin
         e = sb.pop_front();
         chk(name, o_tx_data, e);
      end
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_gnt"}, o_gnt, 0);
      chk({name, "_owner"}, o_owner, 0);
      chk({name, "_busy"}, o_busy, 0);
      chk({name, "_send"}, o_tx_send, 0);
      chk({name, "_data"}, o_tx_data, 0);
      chk({name, "_timeout"}, o_timeout, 0);
   endtask

   task automatic run_vec(input vec_t v);
      @(negedge clk);
      i_req  = v.req;
      i_data = v.data;
      sb.push_back(v.word);
      @(posedge clk); #1;
      chk("gnt", o_gnt, v.gnt);
      chk("owner", o_owner, v.own);
      chk("busy_on", o_busy, 1);
      @(posedge clk); #1;
      chk("gnt_pulse", o_gnt, 0);
      chk("send", o_tx_send, 1);
      chk_sb("tx_data");
      repeat (v.act_dly) begin
         @(posedge clk); #1;
         chk("send_hold", o_tx_send, 1);
      end
      @(negedge clk);
      i_tx_active = 1'b1;
      i_tx_done   = v.same_cycle;
      @(posedge clk); #1;
      chk("send_clr", o_tx_send, 0);
      if (v.same_cycle) begin
         chk("busy_fast", o_busy, 0);
      end else begin
         @(negedge clk);
         i_tx_done = 1'b0;
         if (v.mid_en) i_data[v.own*8 +: 8] = 8'hAA;
         repeat (3) @(posedge clk);
         #1;
         chk("busy_frame", o_busy, 1);
         chk("data_stable", o_tx_data, v.word);
         @(negedge clk);
         i_tx_active = 1'b0;
         i_tx_done   = 1'b1;
         @(posedge clk); #1;
         chk("busy_off", o_busy, 0);
      end
      @(negedge clk);
      i_tx_active = 1'b0;
      i_tx_done   = 1'b0;
      i_req       = 4'b0000;
   endtask

   task automatic finish_frame(input logic [7:0] word);
      @(negedge clk);
      i_req = 4'b0000;
      sb.push_back(word);
      @(posedge clk); #1;
      chk("ff_send", o_tx_send, 1);
      chk_sb("ff_data");
      @(negedge clk);
      i_tx_active = 1'b1;
      i_tx_done   = 1'b1;
      @(posedge clk); #1;
      chk("ff_busy_off", o_busy, 0);
      @(negedge clk);
      i_tx_active = 1'b0;
      i_tx_done   = 1'b0;
   endtask

   initial begin
      //           req      data          gnt      own word  dly mid same
      vecs[0]  = '{4'b1111, 32'h44434241, 4'b0001, 0, 8'h41, 1, 0, 0};
      vecs[1]  = '{4'b1111, 32'h44434241, 4'b0010, 1, 8'h42, 0, 0, 0};
      vecs[2]  = '{4'b1111, 32'h44434241, 4'b0100, 2, 8'h43, 2, 0, 0};
      vecs[3]  = '{4'b1111, 32'h44434241, 4'b1000, 3, 8'h44, 0, 0, 0};
      vecs[4]  = '{4'b1111, 32'h44434241, 4'b0001, 0, 8'h41, 1, 0, 0};
      vecs[5]  = '{4'b0100, 32'h44484241, 4'b0100, 2, 8'h48, 2, 0, 0};
      vecs[6]  = '{4'b1000, 32'h44434241, 4'b1000, 3, 8'h44, 0, 0, 0};
      vecs[7]  = '{4'b1001, 32'h44434241, 4'b0001, 0, 8'h41, 0, 0, 0};
      vecs[8]  = '{4'b0010, 32'h44435541, 4'b0010, 1, 8'h55, 1, 1, 0};
      vecs[9]  = '{4'b0011, 32'h44434241, 4'b0001, 0, 8'h41, 0, 0, 1};
      vecs[10] = '{4'b0011, 32'h44434241, 4'b0010, 1, 8'h42, 3, 0, 0};

      i_rst       = 1'b1;
      i_req       = 4'b0000;
      i_data      = 32'h0;
      i_tx_active = 1'b0;
      i_tx_done   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      @(negedge clk);
      i_rst = 1'b0;

      for (int i = 0; i < 11; i++) run_vec(vecs[i]);

      // Reset while waiting for done; transmitter keeps running and blocks the next grant
      @(negedge clk);
      i_req  = 4'b0100;
      i_data = 32'h44434241;
      @(posedge clk); #1;
      chk("rst_seq_gnt", o_gnt, 4'b0100);
      @(negedge clk);
      i_req = 4'b0000;
      @(posedge clk); #1;
      chk("rst_seq_send", o_tx_send, 1);
      @(negedge clk);
      i_tx_active = 1'b1;
      @(posedge clk); #1;
      chk("rst_seq_wait", o_busy, 1);
      @(negedge clk);
      i_rst = 1'b1;
      @(posedge clk); #1;
      chk_all_zero("mid_reset");
      @(negedge clk);
      i_rst = 1'b0;
      i_req = 4'b1010;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         chk("blocked_gnt", o_gnt, 0);
      end
      @(negedge clk);
      i_tx_active = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_gnt", o_gnt, 4'b0010);
      chk("post_rst_owner", o_owner, 1);
      finish_frame(8'h42);

`ifdef UART_TX_ARBITER_TIMEOUT_EN
      @(negedge clk);
      i_req = 4'b0001;
      @(posedge clk); #1;
      chk("wd_gnt", o_gnt, 4'b0001);
      @(negedge clk);
      i_req = 4'b0010;
      @(posedge clk); #1;
      chk("wd_send", o_tx_send, 1);
      for (int c = 1; c < 16; c++) begin
         @(posedge clk); #1;
         chk("wd_quiet", o_timeout, 0);
      end
      @(posedge clk); #1;
      chk("wd_pulse", o_timeout, 1);
      chk("wd_busy", o_busy, 0);
      chk("wd_send_clr", o_tx_send, 0);
      @(posedge clk); #1;
      chk("wd_pulse_end", o_timeout, 0);
      chk("wd_next_gnt", o_gnt, 4'b0010);
      finish_frame(8'h42);
`else
      @(negedge clk);
      i_req = 4'b0001;
      @(posedge clk); #1;
      chk("nowd_gnt", o_gnt, 4'b0001);
      @(negedge clk);
      i_req = 4'b0000;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         chk("nowd_timeout", o_timeout, 0);
      end
      chk("nowd_busy", o_busy, 1);
      chk("nowd_send", o_tx_send, 1);
      @(negedge clk);
      i_tx_active = 1'b1;
      i_tx_done   = 1'b1;
      @(posedge clk); #1;
      chk("nowd_done", o_busy, 0);
      @(negedge clk);
      i_tx_active = 1'b0;
      i_tx_done   = 1'b0;
`endif

      chk("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
